// File: rtl/alu_share_arbiter_pkg.sv
// Shared widths and FSM state type for the ALU sharing arbiter.
package alu_share_arbiter_pkg;
  localparam int WIDTH   = 32;
  localparam int CTRL_W  = 4;
  localparam int REQ_CNT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the consumer and the arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH  = alu_share_arbiter_pkg::WIDTH,
  parameter int CTRL_W = alu_share_arbiter_pkg::CTRL_W
);
  import alu_share_arbiter_pkg::*;

  logic [REQ_CNT-1:0] req_valid;
  logic [REQ_CNT-1:0] req_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req0_b;
  logic [WIDTH-1:0]   req1_b;
  logic [CTRL_W-1:0]  req0_ctrl;
  logic [CTRL_W-1:0]  req1_ctrl;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic               rsp_carry;
  logic               rsp_ovf;

  modport master (
    output req_valid, req0_a, req1_a, req0_b, req1_b, req0_ctrl, req1_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf
  );

  modport slave (
    input  req_valid, req0_a, req1_a, req0_b, req1_b, req0_ctrl, req1_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin pick; on a tie the requester that did not win last time goes first.
module alu_share_arbiter_rr_arb2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);
  always_comb begin
    gnt_valid_o = |req_valid_i;
    if (&req_valid_i) gnt_id_o = ~last_grant_i;
    else              gnt_id_o = req_valid_i[1];
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with registered operands and a tagged response.
// state | meaning
// IDLE  | arbitrate; accept one request   EXEC | ALU settles   RESP | hold response until consumed
module alu_share_arbiter #(
  parameter int WIDTH  = alu_share_arbiter_pkg::WIDTH,
  parameter int CTRL_W = alu_share_arbiter_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]  alu_a_o,
  output logic [WIDTH-1:0]  alu_b_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [WIDTH-1:0]  alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_carryout_i,
  input  logic              alu_overflow_i,
  output logic              busy_o
);
  import alu_share_arbiter_pkg::*;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d, rsp_carry_q, rsp_carry_d, rsp_ovf_q, rsp_ovf_d;
  logic               gnt_valid, gnt_id, accept;

  alu_share_arbiter_rr_arb2 u_arb (
    .req_valid_i  (bus.req_valid),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  assign accept = (state_q == IDLE) && gnt_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_id] = 1'b1;
    busy_o = (state_q == EXEC) || (state_q == RESP);
  end

  // Operands are sampled only in the accept cycle; the response is captured at the end of EXEC.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;
    if (accept) begin
      last_grant_d = gnt_id;
      owner_d      = gnt_id;
      alu_a_d      = gnt_id ? bus.req1_a    : bus.req0_a;
      alu_b_d      = gnt_id ? bus.req1_b    : bus.req0_b;
      alu_ctrl_d   = gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
    end
    if (state_q == EXEC) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = owner_q;
      rsp_result_d = alu_result_i;
      rsp_zero_d   = alu_zero_i;
      rsp_carry_d  = alu_carryout_i;
      rsp_ovf_d    = alu_overflow_i;
    end
    if ((state_q == RESP) && bus.rsp_ready) rsp_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_ctrl_o     = alu_ctrl_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with an adder ALU stub and a behavioural arbitration model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus ();

  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_zero, alu_carry, alu_ovf, busy;
  logic [WIDTH:0]    stub_sum;

  alu_share_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_ctrl_o     (alu_ctrl),
    .alu_result_i   (alu_result),
    .alu_zero_i     (alu_zero),
    .alu_carryout_i (alu_carry),
    .alu_overflow_i (alu_ovf),
    .busy_o         (busy)
  );

  assign stub_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = stub_sum[WIDTH-1:0];
  assign alu_zero   = (alu_result == '0);
  assign alu_carry  = stub_sum[WIDTH];
  assign alu_ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a[WIDTH-1]);

  typedef struct {
    logic              id;
    logic [WIDTH-1:0]  a, b, res;
    logic [CTRL_W-1:0] ctrl;
    logic              z, c, v;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [CTRL_W-1:0] ctrl);
    exp_t           e;
    longint unsigned us;
    longint         ss;
    us     = {32'd0, a} + {32'd0, b};
    ss     = longint'($signed(a)) + longint'($signed(b));
    e.id   = id;
    e.a    = a;
    e.b    = b;
    e.ctrl = ctrl;
    e.res  = us[31:0];
    e.c    = us[32];
    e.z    = (e.res == 0);
    e.v    = (ss != longint'($signed(e.res)));
    return e;
  endfunction

  // Reference model state: is the shared ALU free, who won last, cycles since accept.
  bit          mdl_idle = 1'b1;
  logic        mdl_last = 1'b1;
  int          lat = -1;
  bit          hold_prev = 1'b0;
  bit          just_reset = 1'b0;
  logic [35:0] prev_rsp;
  logic [1:0]  exp_rdy;
  logic        g;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready_in_reset", bus.req_ready, 2'b00);
      sb.delete();
      mdl_idle   = 1'b1;
      mdl_last   = 1'b1;
      lat        = -1;
      hold_prev  = 1'b0;
      just_reset = 1'b1;
    end else begin
      if (lat >= 0) lat++;
      if (just_reset) begin
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_alu_ctrl", alu_ctrl, 0);
        chk("reset_rsp_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf}, 0);
        just_reset = 1'b0;
      end
      chk("busy", busy, !mdl_idle);
      chk("rsp_valid", bus.rsp_valid, (lat >= 2));
      exp_rdy = 2'b00;
      g       = 1'b0;
      if (mdl_idle && bus.req_valid != 2'b00) begin
        g = (bus.req_valid == 2'b11) ? ~mdl_last : bus.req_valid[1];
        exp_rdy[g] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      if (lat == 1 && sb.size() > 0) begin
        chk("exec_alu_ctrl", alu_ctrl, sb[0].ctrl);
        chk("exec_alu_ab", {alu_a, alu_b}, {sb[0].a, sb[0].b});
      end
      if (bus.rsp_valid) begin
        if (hold_prev)
          chk("rsp_stable", {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf}, prev_rsp);
        if (bus.rsp_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got a response with id %0d, required none", bus.rsp_id);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_result", bus.rsp_result, e.res);
            chk("rsp_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf}, {e.z, e.c, e.v});
          end
          mdl_idle = 1'b1;
          lat      = -1;
        end
        hold_prev = !bus.rsp_ready;
        prev_rsp  = {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf};
      end else begin
        hold_prev = 1'b0;
      end
      if (exp_rdy != 2'b00) begin
        if (g) sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_ctrl));
        else   sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_ctrl));
        mdl_last = g;
        mdl_idle = 1'b0;
        lat      = 0;
      end
    end
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [CTRL_W-1:0] c);
    if (i == 0) begin bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c; end
    else        begin bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c; end
  endtask

  task automatic rand_op(input int i);
    logic [WIDTH-1:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'hFFFF_FFFF;
      1:       a = 32'h7FFF_FFFF;
      default: a = $urandom;
    endcase
    set_op(i, a, ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom, 4'($urandom_range(0, 15)));
  endtask

  // Issue n0/n1 operations; each requester holds until accepted, then moves to fresh operands.
  task automatic run(input int n0, input int n1, input int rdy_pct, input int hold_n, input int budget);
    int         left0, left1, vcnt;
    bit         done;
    logic [1:0] acc;
    left0 = n0;
    left1 = n1;
    vcnt  = 0;
    done  = 1'b0;
    bus.req_valid = {1'(n1 > 0), 1'(n0 > 0)};
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (hold_n > 0) bus.rsp_ready = (vcnt >= hold_n);
      else            bus.rsp_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (bus.rsp_valid && !bus.rsp_ready) vcnt++;
      else                                 vcnt = 0;
      @(posedge clk);
      #1;
      if (acc[0]) begin left0--; if (left0 > 0) rand_op(0); else bus.req_valid[0] = 1'b0; end
      if (acc[1]) begin left1--; if (left1 > 0) rand_op(1); else bus.req_valid[1] = 1'b0; end
      if (left0 == 0 && left1 == 0 && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("run_complete", done, 1);
  endtask

  task automatic wait_acc(input int i, input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_seen", got, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    set_op(0, 32'd1, 32'd1, 4'h0);
    set_op(1, 32'd2, 32'd2, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 2'b00;

    set_op(0, 32'd5, 32'd3, 4'h2);
    run(1, 0, 100, 0, 50);

    set_op(0, 32'd100, 32'd23, 4'h0);
    set_op(1, 32'd7, 32'd8, 4'hF);
    run(4, 4, 100, 0, 200);

    set_op(0, 32'd40, 32'd2, 4'h1);
    set_op(1, 32'd300, 32'd12, 4'h7);
    run(1, 1, 0, 5, 200);

    set_op(0, 32'hFFFF_FFFF, 32'd1, 4'h6);
    run(1, 0, 100, 0, 50);
    set_op(0, 32'h7FFF_FFFF, 32'd1, 4'h6);
    run(1, 0, 100, 0, 50);

    set_op(0, 32'd1, 32'd2, 4'h3);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    wait_acc(0, 20);
    bus.req_valid = 2'b00;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_op(0, 32'd11, 32'd22, 4'h1);
    set_op(1, 32'd33, 32'd44, 4'h2);
    run(1, 1, 100, 0, 100);

    set_op(0, 32'd10, 32'd5, 4'h3);
    bus.req_valid = 2'b01;
    wait_acc(0, 20);
    bus.req_valid = 2'b00;
    bus.req0_a    = 32'd99;
    run(0, 0, 100, 0, 50);

    rand_op(0);
    rand_op(1);
    run(30, 30, 60, 0, 3000);
    rand_op(0);
    rand_op(1);
    run(20, 10, 30, 0, 3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
